// File: rtl/arc4_pkg.sv
// Shared ARC4 PRGA definitions: FSM state encoding, memory constants and
// the printable-character test applied to decrypted bytes.
package arc4_pkg;

  typedef enum logic [3:0] {
    IDLE, RD_LEN, LEN, RD_SI, RD_SJ, WR_I, WR_J, RD_PAD, WR_PT
  } state_e;

  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;
  localparam logic [7:0] LEN_ADDR = 8'h00;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= PRINT_LO) && (b <= PRINT_HI);
  endfunction

endpackage

// File: rtl/prga_xor.sv
// ARC4 keystream generator and decryptor: walks a pre-scheduled S-box,
// XORs the keystream with ct[1..L] and writes pt[0..L], six states per byte.
module prga_xor
  import arc4_pkg::*;
#(
  parameter bit CHECK_PRINTABLE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic       bad,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren
);

  state_e     state_q, state_d;
  logic [7:0] i_q, i_d, j_q, j_d, k_q, k_d, len_q, len_d;
  logic [7:0] si_q, si_d, sj_q, sj_d;
  logic       bad_q, bad_d;
  logic [7:0] pt_byte;

  assign pt_byte = s_rddata ^ ct_rddata;
  assign rdy     = (state_q == IDLE);
  assign bad     = bad_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      len_q   <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      len_q   <= len_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      bad_q   <= bad_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    len_d     = len_q;
    si_d      = si_q;
    sj_d      = sj_q;
    bad_d     = bad_q;
    s_addr    = '0;
    s_wrdata  = '0;
    s_wren    = 1'b0;
    ct_addr   = '0;
    pt_addr   = '0;
    pt_wrdata = '0;
    pt_wren   = 1'b0;
    case (state_q)
      IDLE: if (en) begin
        i_d     = '0;
        j_d     = '0;
        k_d     = '0;
        bad_d   = 1'b0;
        state_d = RD_LEN;
      end
      RD_LEN: begin
        ct_addr = LEN_ADDR;
        state_d = LEN;
      end
      LEN: begin
        len_d     = ct_rddata;
        pt_addr   = LEN_ADDR;
        pt_wrdata = ct_rddata;
        pt_wren   = 1'b1;
        if (ct_rddata == 8'd0) state_d = IDLE;
        else begin
          k_d     = 8'd1;
          state_d = RD_SI;
        end
      end
      RD_SI: begin
        i_d     = i_q + 8'd1;
        s_addr  = i_q + 8'd1;
        state_d = RD_SJ;
      end
      RD_SJ: begin
        si_d    = s_rddata;
        s_addr  = j_q + s_rddata;
        j_d     = j_q + s_rddata;
        state_d = WR_I;
      end
      WR_I: begin
        sj_d     = s_rddata;
        s_addr   = i_q;
        s_wrdata = s_rddata;
        s_wren   = 1'b1;
        state_d  = WR_J;
      end
      WR_J: begin
        s_addr   = j_q;
        s_wrdata = si_q;
        s_wren   = 1'b1;
        ct_addr  = k_q;
        state_d  = RD_PAD;
      end
      // ct_addr stays on k so ct_rddata is still valid in WR_PT
      RD_PAD: begin
        s_addr  = si_q + sj_q;
        ct_addr = k_q;
        state_d = WR_PT;
      end
      WR_PT: begin
        pt_addr   = k_q;
        pt_wrdata = pt_byte;
        pt_wren   = 1'b1;
        if (CHECK_PRINTABLE && !is_printable(pt_byte)) begin
          bad_d   = 1'b1;
          state_d = IDLE;
        end else if (k_q == len_q) begin
          state_d = IDLE;
        end else begin
          k_d     = k_q + 8'd1;
          state_d = RD_SI;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_prga_xor.sv
// Scoreboard bench for prga_xor: expected pt writes are queued by stimulus
// and checked by an independent monitor on every pt_wren.
module tb_prga_xor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       rdy, bad;
  logic [7:0] s_addr, s_rddata, s_wrdata;
  logic       s_wren;
  logic [7:0] ct_addr, ct_rddata, pt_addr, pt_wrdata;
  logic       pt_wren;

  logic [7:0] smem [256];
  logic [7:0] ctmem[256];
  logic [7:0] ptmem[256];
  logic [15:0] exp_q[$];
  logic [15:0] mon_e;
  int nchk = 0;
  int errs = 0;

  prga_xor #(.CHECK_PRINTABLE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .bad(bad),
    .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
    .ct_addr(ct_addr), .ct_rddata(ct_rddata),
    .pt_addr(pt_addr), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren)
  );

  always #5 clk = ~clk;

  // synchronous memories, one-cycle read latency, read-before-write
  always @(posedge clk) begin
    s_rddata  <= smem[s_addr];
    ct_rddata <= ctmem[ct_addr];
    if (s_wren)  smem[s_addr]   <= s_wrdata;
    if (pt_wren) ptmem[pt_addr] <= pt_wrdata;
  end

  always @(negedge clk) begin
    if (pt_wren) begin
      nchk++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL pt_unexpected addr=%02h data=%02h", pt_addr, pt_wrdata);
      end else begin
        mon_e = exp_q.pop_front();
        if ({pt_addr, pt_wrdata} !== mon_e) begin
          errs++;
          $display("FAIL pt_write got addr=%02h data=%02h want addr=%02h data=%02h",
                   pt_addr, pt_wrdata, mon_e[15:8], mon_e[7:0]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic ident_sbox();
    for (int x = 0; x < 256; x++) begin
      smem[x]  = x[7:0];
      ptmem[x] = 8'hEE;
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic run(input string nm, input int exp_low, input bit noise);
    int cnt;
    @(negedge clk); en = 1'b1;
    @(negedge clk); en = 1'b0;
    cnt = 0;
    while (rdy == 1'b0 && cnt < 4000) begin
      cnt++;
      if (noise) en = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    en = 1'b0;
    chk({nm, "_rdy_low_cycles"}, cnt, exp_low);
    chk({nm, "_pending_writes"}, exp_q.size(), 0);
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_rdy"}, rdy, 1);
    chk({nm, "_bad"}, bad, 0);
    chk({nm, "_addrs"}, {s_addr, ct_addr, pt_addr}, 0);
    chk({nm, "_wrens"}, {s_wren, pt_wren}, 0);
  endtask

  initial begin
    logic [7:0] sm[256];
    logic [7:0] si, sj, ii, jj, pad, p, tmp;
    int r, sdiff;

    ident_sbox();
    for (int x = 0; x < 256; x++) ctmem[x] = 8'h00;
    #2 chk_reset_outs("reset");
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // identity S-box, three printable bytes
    ctmem[0] = 8'h03; ctmem[1] = 8'h43; ctmem[2] = 8'h44; ctmem[3] = 8'h46;
    push(8'h00, 8'h03); push(8'h01, 8'h41); push(8'h02, 8'h41); push(8'h03, 8'h41);
    run("basic", 20, 1'b0);
    chk("basic_bad", bad, 0);
    chk("basic_sbox", {smem[1], smem[2], smem[3], smem[5]}, 32'h01030502);

    // zero-length message
    ident_sbox();
    ctmem[0] = 8'h00;
    push(8'h00, 8'h00);
    run("zero_len", 2, 1'b0);
    chk("zero_len_bad", bad, 0);
    chk("zero_len_pt1", ptmem[1], 8'hEE);

    // first decrypted byte non-printable -> abort
    ident_sbox();
    ctmem[0] = 8'h03; ctmem[1] = 8'h02; ctmem[2] = 8'h44; ctmem[3] = 8'h46;
    push(8'h00, 8'h03); push(8'h01, 8'h00);
    run("nonprint", 8, 1'b0);
    chk("nonprint_bad", bad, 1);
    chk("nonprint_untouched", {ptmem[2], ptmem[3]}, 16'hEEEE);
    repeat (3) @(negedge clk);
    chk("nonprint_bad_held", bad, 1);

    // reset during RD_PAD of byte 2 (low cycle 13)
    ident_sbox();
    ctmem[0] = 8'h03; ctmem[1] = 8'h43; ctmem[2] = 8'h44; ctmem[3] = 8'h46;
    push(8'h00, 8'h03); push(8'h01, 8'h41);
    @(negedge clk); en = 1'b1;
    @(negedge clk); en = 1'b0;
    repeat (12) @(negedge clk);
    chk("midreset_state_rdy", rdy, 0);
    #2 rst_n = 1'b0;
    #1 chk_reset_outs("midreset");
    repeat (3) @(negedge clk);
    chk("midreset_pt2_untouched", ptmem[2], 8'hEE);
    chk("midreset_pending", exp_q.size(), 0);
    rst_n = 1'b1;
    ident_sbox();
    push(8'h00, 8'h03); push(8'h01, 8'h41); push(8'h02, 8'h41); push(8'h03, 8'h41);
    run("restart", 20, 1'b0);
    chk("restart_bad", bad, 0);

    // L=255, shuffled S-box, software ARC4 model, en noise during run
    ident_sbox();
    for (int x = 255; x > 0; x--) begin
      r = $urandom_range(0, x);
      tmp = smem[x]; smem[x] = smem[r]; smem[r] = tmp;
    end
    for (int x = 0; x < 256; x++) sm[x] = smem[x];
    ctmem[0] = 8'hFF;
    push(8'h00, 8'hFF);
    ii = 8'd0; jj = 8'd0;
    for (int k = 1; k < 256; k++) begin
      ii = ii + 8'd1;
      si = sm[ii];
      jj = jj + si;
      sj = sm[jj];
      sm[ii] = sj; sm[jj] = si;
      pad = sm[8'(si + sj)];
      p = 8'($urandom_range(32, 126));
      ctmem[k] = p ^ pad;
      push(8'(k), p);
    end
    run("long", 2 + 6 * 255, 1'b1);
    chk("long_bad", bad, 0);
    sdiff = 0;
    for (int x = 0; x < 256; x++) if (smem[x] !== sm[x]) sdiff++;
    chk("long_sbox_diffs", sdiff, 0);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, errs);
    $finish;
  end

endmodule
